// File: rtl/rvh_noc_pkg.sv
// Shared NoC router types and width helpers used by the input VC buffer.
package rvh_noc_pkg;

    function automatic int noc_vc_id_w(input int vc_num);
        return (vc_num > 1) ? $clog2(vc_num) : 1;
    endfunction

    function automatic int noc_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int NOC_VC_NUM   = 6;
    localparam int NOC_VC_DEPTH = 4;
    localparam int NOC_FLIT_W   = 256;
    localparam int NOC_QOS_W    = 4;
    localparam int NOC_VC_ID_W  = noc_vc_id_w(NOC_VC_NUM);
    localparam int NOC_CNT_W    = noc_cnt_w(NOC_VC_DEPTH);

    // Default-width records; parametrised instances declare the same shape locally.
    typedef struct packed {
        logic [NOC_FLIT_W-1:0] flit;
        logic [NOC_QOS_W-1:0]  qos;
    } noc_vc_head_t;

    typedef struct packed {
        logic                   vld;
        logic [NOC_VC_ID_W-1:0] vc_id;
    } noc_credit_t;

endpackage

// File: rtl/noc_vc_fifo.sv
// Single-VC circular flit FIFO with explicit pointer wrap (any depth >= 1).
module noc_vc_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     head,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] cnt_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage is intentionally left unreset; head is only meaningful when non-empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign cnt   = cnt_q;
    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/noc_input_vc_buffer.sv
// Per-input-port VC flit buffer: per-VC FIFOs, QoS head ranking, credit return.
// Optional NOC_VC_BUF_EARLY_CREDIT_EN makes the credit combinational from the pop.
module noc_input_vc_buffer
    import rvh_noc_pkg::*;
#(
    parameter  int VC_NUM   = 6,
    parameter  int VC_DEPTH = 4,
    parameter  int FLIT_W   = 256,
    parameter  int QOS_W    = 4,
    localparam int VC_ID_W  = noc_vc_id_w(VC_NUM),
    localparam int CNT_W    = noc_cnt_w(VC_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wr_vld_i,
    input  logic [VC_ID_W-1:0]       wr_vc_id_i,
    input  logic [FLIT_W-1:0]        wr_flit_i,
    input  logic [QOS_W-1:0]         wr_qos_i,
    input  logic                     rd_vld_i,
    input  logic [VC_ID_W-1:0]       rd_vc_id_i,
    output logic [VC_NUM-1:0]        head_vld_o,
    output logic [VC_NUM*FLIT_W-1:0] head_flit_o,
    output logic [VC_NUM*QOS_W-1:0]  head_qos_o,
    output logic [VC_NUM*CNT_W-1:0]  vc_cnt_o,
    output logic                     sel_vld_o,
    output logic [VC_ID_W-1:0]       sel_vc_id_o,
    output logic                     credit_vld_o,
    output logic [VC_ID_W-1:0]       credit_vc_id_o,
    output logic                     ovf_err_o,
    output logic                     udf_err_o
);
    typedef struct packed {
        logic [FLIT_W-1:0] flit;
        logic [QOS_W-1:0]  qos;
    } vc_head_t;

    typedef struct packed {
        logic               vld;
        logic [VC_ID_W-1:0] vc_id;
    } credit_t;

    vc_head_t          heads [VC_NUM];
    vc_head_t          wr_rec;
    logic [VC_NUM-1:0] full, empty, push_hit, pop_hit;
    logic              push_ok, pop_ok;
    logic              ovf_q, udf_q;
    credit_t           credit_now, credit;

    assign wr_rec = '{flit: wr_flit_i, qos: wr_qos_i};

    // Out-of-range IDs match no VC, so they fall out as rejected pushes/pops.
    always_comb begin
        push_hit = '0;
        pop_hit  = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            pop_hit[v]  = rd_vld_i && (rd_vc_id_i == VC_ID_W'(v)) && !empty[v];
            push_hit[v] = wr_vld_i && (wr_vc_id_i == VC_ID_W'(v)) && (!full[v] || pop_hit[v]);
        end
    end

    assign push_ok = |push_hit;
    assign pop_ok  = |pop_hit;

    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
        noc_vc_fifo #(
            .DEPTH (VC_DEPTH),
            .W     (FLIT_W + QOS_W),
            .CNT_W (CNT_W)
        ) u_fifo (
            .clk   (clk),
            .rstn  (rstn),
            .push  (push_hit[v]),
            .pop   (pop_hit[v]),
            .din   (wr_rec),
            .head  (heads[v]),
            .cnt   (vc_cnt_o[v*CNT_W +: CNT_W]),
            .full  (full[v]),
            .empty (empty[v])
        );
        assign head_vld_o[v]                  = !empty[v];
        assign head_flit_o[v*FLIT_W +: FLIT_W] = heads[v].flit;
        assign head_qos_o[v*QOS_W +: QOS_W]    = heads[v].qos;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (wr_vld_i && !push_ok) ovf_q <= 1'b1;
            if (rd_vld_i && !pop_ok)  udf_q <= 1'b1;
        end
    end

    assign ovf_err_o = ovf_q;
    assign udf_err_o = udf_q;

    // Strict '>' keeps the lowest index on QoS ties.
    always_comb begin
        logic [QOS_W-1:0] best_qos;
        best_qos    = '0;
        sel_vld_o   = 1'b0;
        sel_vc_id_o = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            if (!empty[v] && (!sel_vld_o || heads[v].qos > best_qos)) begin
                sel_vld_o   = 1'b1;
                best_qos    = heads[v].qos;
                sel_vc_id_o = VC_ID_W'(v);
            end
        end
    end

    always_comb begin
        credit_now.vld   = pop_ok;
        credit_now.vc_id = pop_ok ? rd_vc_id_i : '0;
    end

`ifdef NOC_VC_BUF_EARLY_CREDIT_EN
    assign credit = credit_now;
`else
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) credit <= '0;
        else       credit <= credit_now;
    end
`endif

    assign credit_vld_o   = credit.vld;
    assign credit_vc_id_o = credit.vc_id;

endmodule

// File: tb/tb_noc_input_vc_buffer.sv
// Randomised + directed bench for noc_input_vc_buffer against a per-VC queue model.
module tb_noc_input_vc_buffer;
    localparam int VC_NUM   = 6;
    localparam int VC_DEPTH = 4;
    localparam int FLIT_W   = 32;
    localparam int QOS_W    = 4;
    localparam int VC_ID_W  = 3;
    localparam int CNT_W    = 3;
    localparam int E_W      = FLIT_W + QOS_W;
    localparam int W_DEPTH  = 3;
    localparam int W_CNT_W  = 2;

    // clock / reset
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic                     wr_vld_i = 1'b0;
    logic [VC_ID_W-1:0]       wr_vc_id_i = '0;
    logic [FLIT_W-1:0]        wr_flit_i = '0;
    logic [QOS_W-1:0]         wr_qos_i = '0;
    logic                     rd_vld_i = 1'b0;
    logic [VC_ID_W-1:0]       rd_vc_id_i = '0;
    logic [VC_NUM-1:0]        head_vld_o;
    logic [VC_NUM*FLIT_W-1:0] head_flit_o;
    logic [VC_NUM*QOS_W-1:0]  head_qos_o;
    logic [VC_NUM*CNT_W-1:0]  vc_cnt_o;
    logic                     sel_vld_o, credit_vld_o, ovf_err_o, udf_err_o;
    logic [VC_ID_W-1:0]       sel_vc_id_o, credit_vc_id_o;

    noc_input_vc_buffer #(.VC_NUM(VC_NUM), .VC_DEPTH(VC_DEPTH), .FLIT_W(FLIT_W), .QOS_W(QOS_W)) dut (
        .clk(clk), .rstn(rstn),
        .wr_vld_i(wr_vld_i), .wr_vc_id_i(wr_vc_id_i), .wr_flit_i(wr_flit_i), .wr_qos_i(wr_qos_i),
        .rd_vld_i(rd_vld_i), .rd_vc_id_i(rd_vc_id_i),
        .head_vld_o(head_vld_o), .head_flit_o(head_flit_o), .head_qos_o(head_qos_o), .vc_cnt_o(vc_cnt_o),
        .sel_vld_o(sel_vld_o), .sel_vc_id_o(sel_vc_id_o),
        .credit_vld_o(credit_vld_o), .credit_vc_id_o(credit_vc_id_o),
        .ovf_err_o(ovf_err_o), .udf_err_o(udf_err_o)
    );

    // Second instance with a non-power-of-two depth for the wrap check.
    logic                      w_wr_vld = 1'b0, w_rd_vld = 1'b0;
    logic [VC_ID_W-1:0]        w_wr_vc_id = 3'd3, w_rd_vc_id = 3'd3;
    logic [FLIT_W-1:0]         w_wr_flit = '0;
    logic [QOS_W-1:0]          w_wr_qos = '0;
    logic [VC_NUM-1:0]         w_head_vld;
    logic [VC_NUM*FLIT_W-1:0]  w_head_flit;
    logic [VC_NUM*QOS_W-1:0]   w_head_qos;
    logic [VC_NUM*W_CNT_W-1:0] w_vc_cnt;
    logic                      w_sel_vld, w_credit_vld, w_ovf, w_udf;
    logic [VC_ID_W-1:0]        w_sel_vc_id, w_credit_vc_id;

    noc_input_vc_buffer #(.VC_NUM(VC_NUM), .VC_DEPTH(W_DEPTH), .FLIT_W(FLIT_W), .QOS_W(QOS_W)) dut_wrap (
        .clk(clk), .rstn(rstn),
        .wr_vld_i(w_wr_vld), .wr_vc_id_i(w_wr_vc_id), .wr_flit_i(w_wr_flit), .wr_qos_i(w_wr_qos),
        .rd_vld_i(w_rd_vld), .rd_vc_id_i(w_rd_vc_id),
        .head_vld_o(w_head_vld), .head_flit_o(w_head_flit), .head_qos_o(w_head_qos), .vc_cnt_o(w_vc_cnt),
        .sel_vld_o(w_sel_vld), .sel_vc_id_o(w_sel_vc_id),
        .credit_vld_o(w_credit_vld), .credit_vc_id_o(w_credit_vc_id),
        .ovf_err_o(w_ovf), .udf_err_o(w_udf)
    );

    // scoreboard / reference model
    logic [E_W-1:0]    exp_q [VC_NUM][$];
    logic [FLIT_W-1:0] wrap_q [$];
    bit exp_ovf, exp_udf, exp_cred_vld;
    int exp_cred_id;
    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < VC_NUM; v++) exp_q[v].delete();
        exp_ovf = 0; exp_udf = 0; exp_cred_vld = 0; exp_cred_id = 0;
    endtask

    task automatic check_outputs(input bit pop_now, input int rid_now);
        logic [VC_NUM-1:0]       ev;
        logic [VC_NUM*CNT_W-1:0] ec;
        int max_q, sel, cid;
        bit cv;
        ev = '0; ec = '0; max_q = -1; sel = 0;
        for (int v = 0; v < VC_NUM; v++) begin
            ev[v] = exp_q[v].size() > 0;
            ec[v*CNT_W +: CNT_W] = CNT_W'(exp_q[v].size());
            if (ev[v]) begin
                check("head_flit", head_flit_o[v*FLIT_W +: FLIT_W], exp_q[v][0][FLIT_W-1:0]);
                check("head_qos", head_qos_o[v*QOS_W +: QOS_W], exp_q[v][0][E_W-1:FLIT_W]);
                if (int'(exp_q[v][0][E_W-1:FLIT_W]) > max_q) max_q = int'(exp_q[v][0][E_W-1:FLIT_W]);
            end
        end
        for (int v = VC_NUM - 1; v >= 0; v--)
            if (ev[v] && int'(exp_q[v][0][E_W-1:FLIT_W]) == max_q) sel = v;
        check("head_vld", head_vld_o, ev);
        check("vc_cnt", vc_cnt_o, ec);
        check("sel_vld", sel_vld_o, |ev);
        check("sel_vc_id", sel_vc_id_o, sel);
`ifdef NOC_VC_BUF_EARLY_CREDIT_EN
        cv = pop_now; cid = rid_now;
`else
        cv = exp_cred_vld; cid = exp_cred_id;
`endif
        check("credit_vld", credit_vld_o, cv);
        if (cv) check("credit_vc_id", credit_vc_id_o, cid);
        check("ovf_err", ovf_err_o, exp_ovf);
        check("udf_err", udf_err_o, exp_udf);
    endtask

    // driver: one clock cycle on the main instance, entered and left at negedge
    task automatic drive_cycle(input bit wv, input int wid, input logic [FLIT_W-1:0] wf,
                               input logic [QOS_W-1:0] wq, input bit rv, input int rid);
        bit pop_ok, push_ok;
        wr_vld_i = wv; wr_vc_id_i = VC_ID_W'(wid); wr_flit_i = wf; wr_qos_i = wq;
        rd_vld_i = rv; rd_vc_id_i = VC_ID_W'(rid);
        #1;
        pop_ok = 0; push_ok = 0;
        if (rv && rid < VC_NUM) pop_ok = exp_q[rid].size() > 0;
        if (wv && wid < VC_NUM) push_ok = (exp_q[wid].size() < VC_DEPTH) || (pop_ok && rid == wid);
        check_outputs(pop_ok, rid);
        @(posedge clk);
        if (pop_ok)  void'(exp_q[rid].pop_front());
        if (push_ok) exp_q[wid].push_back({wq, wf});
        if (wv && !push_ok) exp_ovf = 1;
        if (rv && !pop_ok)  exp_udf = 1;
        exp_cred_vld = pop_ok;
        exp_cred_id  = pop_ok ? rid : 0;
        @(negedge clk);
        wr_vld_i = 1'b0; rd_vld_i = 1'b0;
    endtask

    task automatic push(input int vc, input logic [FLIT_W-1:0] f, input logic [QOS_W-1:0] q);
        drive_cycle(1, vc, f, q, 0, 0);
    endtask

    task automatic pop(input int vc);
        drive_cycle(0, 0, '0, '0, 1, vc);
    endtask

    task automatic wrap_cycle(input bit do_push, input bit do_pop, input logic [FLIT_W-1:0] f);
        w_wr_vld = do_push; w_wr_flit = f; w_rd_vld = do_pop;
        #1;
        if (do_pop) check("wrap_head", w_head_flit[3*FLIT_W +: FLIT_W], wrap_q[0]);
        check("wrap_cnt", w_vc_cnt[3*W_CNT_W +: W_CNT_W], wrap_q.size());
        @(posedge clk);
        if (do_pop)  void'(wrap_q.pop_front());
        if (do_push) wrap_q.push_back(f);
        @(negedge clk);
        w_wr_vld = 1'b0; w_rd_vld = 1'b0;
    endtask

    initial begin
        int nxt;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs(0, 0);
        rstn = 1'b1;
        @(negedge clk);

        // fill and drain VC2
        for (int i = 0; i < 4; i++) begin
            push(2, FLIT_W'(32'hA + i), '0);
            check("fill_cnt", vc_cnt_o[2*CNT_W +: CNT_W], i + 1);
        end
        check("fill_head", head_flit_o[2*FLIT_W +: FLIT_W], 32'hA);
        for (int i = 0; i < 4; i++) begin
            pop(2);
`ifndef NOC_VC_BUF_EARLY_CREDIT_EN
            check("drain_credit", {credit_vld_o, credit_vc_id_o}, {1'b1, 3'd2});
`endif
        end
        check("drain_cnt", vc_cnt_o[2*CNT_W +: CNT_W], 0);

        // overflow on VC2, then simultaneous push+pop while full
        for (int i = 0; i < 4; i++) push(2, FLIT_W'(32'h20 + i), 4'd1);
        push(2, 32'hDEAD, 4'd1);
        check("ovf_flag", ovf_err_o, 1);
        check("ovf_cnt", vc_cnt_o[2*CNT_W +: CNT_W], 4);
        drive_cycle(1, 2, 32'h30, 4'd1, 1, 2);
        check("pushpop_cnt", vc_cnt_o[2*CNT_W +: CNT_W], 4);
        for (int i = 0; i < 4; i++) pop(2);

        // underflow on empty VC0
        pop(0);
        check("udf_flag", udf_err_o, 1);
        check("udf_cnt", vc_cnt_o, 0);
`ifndef NOC_VC_BUF_EARLY_CREDIT_EN
        check("udf_no_credit", credit_vld_o, 0);
`endif

        // QoS ranking with a tie between VC4 and VC5
        push(1, 32'h11, 4'd3);
        push(4, 32'h44, 4'd9);
        push(5, 32'h55, 4'd9);
        check("qos_sel", sel_vc_id_o, 4);
        pop(4);
        check("qos_sel_after_pop", sel_vc_id_o, 5);
        pop(1);
        pop(5);

        // random traffic, including out-of-range VC IDs
        for (int i = 0; i < 300; i++)
            drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom, QOS_W'($urandom),
                        $urandom_range(0, 1) == 1, $urandom_range(0, 7));

        // mid-operation reset with several VCs holding flits
        push(0, 32'h100, 4'd2);
        push(1, 32'h101, 4'd5);
        push(3, 32'h103, 4'd7);
        drive_cycle(0, 0, '0, '0, 1, 3);
        #2 rstn = 1'b0;
        #1;
        check("rst_head_vld", head_vld_o, 0);
        check("rst_vc_cnt", vc_cnt_o, 0);
        check("rst_sel", {sel_vld_o, sel_vc_id_o}, 0);
        check("rst_credit", {credit_vld_o, credit_vc_id_o}, 0);
        check("rst_err", {ovf_err_o, udf_err_o}, 0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 150; i++)
            drive_cycle($urandom_range(0, 2) != 0, $urandom_range(0, 6), $urandom, QOS_W'($urandom),
                        $urandom_range(0, 2) != 0, $urandom_range(0, 6));

        // pointer wrap on a depth-3 FIFO
        nxt = 32'h500;
        for (int i = 0; i < 2; i++) begin wrap_cycle(1, 0, FLIT_W'(nxt)); nxt++; end
        for (int i = 0; i < 10; i++) begin
            wrap_cycle(1, 0, FLIT_W'(nxt)); nxt++;
            wrap_cycle(0, 1, '0);
        end
        while (wrap_q.size() > 0) wrap_cycle(0, 1, '0);
        check("wrap_empty", w_head_vld, 0);
        check("wrap_err", {w_ovf, w_udf}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
